// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns fetch PC, buffers {pc, word} pairs fetched from combinational imem.
// Latency: 1 cycle from imem_A presentation to the word appearing on inst (empty buffer); 1 instr/cycle sustained.
// Backpressure: inst_ready=0 fills the DEPTH-entry buffer, then fetch PC holds; branch redirect flushes and reloads.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_A,
    input  logic [31:0] imem_RD,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc8,
    output logic [31:0] fetch_cnt
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Buffer occupancy as seen by the push/pop logic.
    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_cnt_q, fetch_cnt_d;
    logic [31:0]   buf_pc_q   [DEPTH];
    logic [31:0]   buf_word_q [DEPTH];

    occ_e        occ;
    logic        pop;
    logic        push;
    logic [31:0] br_pc;

    // Low address bits of a redirect are dropped: ARM instructions are word aligned.
    assign br_pc = br_target & 32'hFFFF_FFFC;

    // Decode occupancy from the entry count.
    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == FULL_CNT) begin
            occ = OCC_FULL;
        end
    end

    assign inst_valid = (occ != OCC_EMPTY);
    assign pop        = inst_valid & inst_ready;
    // A full buffer can still accept a push when the head leaves in the same cycle.
    assign push       = fetch_en & ~br_valid & ((occ != OCC_FULL) | pop);

    // Next-state for fetch PC, pointers, count and pop counter; redirect overrides push/pop.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fetch_cnt_d = fetch_cnt_q + 32'(pop);
        if (br_valid) begin
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            fetch_pc_d = br_pc;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            fetch_cnt_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Buffer storage: capture the word imem returns for the current fetch PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_pc_q[i]   <= '0;
                buf_word_q[i] <= '0;
            end
        end else if (push) begin
            buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
            buf_word_q[wr_ptr_q] <= imem_RD;
        end
    end

    assign imem_A    = fetch_pc_q;
    assign inst      = buf_word_q[rd_ptr_q];
    assign inst_pc   = buf_pc_q[rd_ptr_q];
    assign inst_pc8  = inst_pc + 32'd8;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Testbench for imem_fetch_ctrl: queue-based reference model plus scoreboard monitor.
// Latency: n/a.
// Backpressure: driven randomly and in directed phases on inst_ready.
module tb_imem_fetch_ctrl;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC1  = 32'h0000_0000;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_A;
    logic [31:0] imem_RD;
    logic        br_valid;
    logic [31:0] br_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc8;
    logic [31:0] fetch_cnt;

    logic        rst2_n;
    logic        fetch_en2;
    logic [31:0] imem_A2;
    logic [31:0] imem_RD2;
    logic        br_valid2;
    logic [31:0] br_target2;
    logic        inst_valid2;
    logic        inst_ready2;
    logic [31:0] inst2;
    logic [31:0] inst_pc2;
    logic [31:0] inst_pc8_2;
    logic [31:0] fetch_cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: expected buffer contents, fetch PC, pop count.
    ent_t        sb[$];
    logic [31:0] m_fpc = RPC1;
    logic [31:0] m_cnt = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_0001;
        if (a == 32'h4) return 32'hE280_0002;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_RD  = memword(imem_A);
    assign imem_RD2 = memword(imem_A2);

    imem_fetch_ctrl #(.RESET_PC(RPC1), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_A(imem_A), .imem_RD(imem_RD),
        .br_valid(br_valid), .br_target(br_target), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_pc8(inst_pc8),
        .fetch_cnt(fetch_cnt)
    );

    imem_fetch_ctrl #(.RESET_PC(RPC2), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst2_n), .fetch_en(fetch_en2), .imem_A(imem_A2), .imem_RD(imem_RD2),
        .br_valid(br_valid2), .br_target(br_target2), .inst_valid(inst_valid2),
        .inst_ready(inst_ready2), .inst(inst2), .inst_pc(inst_pc2), .inst_pc8(inst_pc8_2),
        .fetch_cnt(fetch_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: mid-cycle, compare DUT outputs against the model and retire popped entries.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("inst_valid", {31'd0, inst_valid}, {31'd0, sb.size() != 0});
                chk("imem_A", imem_A, m_fpc);
                chk("fetch_cnt", fetch_cnt, m_cnt);
                if (inst_valid && inst_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("inst", inst, e.word);
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_pc8", inst_pc8, e.pc + 32'd8);
                    m_cnt++;
                end
            end
        end
    end

    // One cycle of stimulus; entered and left just after a rising edge.
    task automatic cyc(input logic fe, input logic rdy, input logic br, input logic [31:0] tgt);
        fetch_en   = fe;
        inst_ready = rdy;
        br_valid   = br;
        br_target  = tgt;
        @(negedge clk);
        #1;
        if (br) begin
            sb.delete();
            m_fpc = tgt & 32'hFFFF_FFFC;
        end else if (fe && sb.size() < DEPTH) begin
            sb.push_back('{pc: m_fpc, word: memword(m_fpc)});
            m_fpc = m_fpc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_imem_A"}, imem_A, RPC1);
        chk({tag, "_fetch_cnt"}, fetch_cnt, 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_inst_pc"}, inst_pc, 32'd0);
        chk({tag, "_inst_pc8"}, inst_pc8, 32'd8);
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        fetch_en = 1'b0; inst_ready = 1'b0; br_valid = 1'b0; br_target = '0;
        fetch_en2 = 1'b1; inst_ready2 = 1'b1; br_valid2 = 1'b0; br_target2 = '0;
        #3;
        reset_checks("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Backpressure right after reset: buffer saturates, fetch PC holds at 0x8.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        chk("bp_imem_A_hold", imem_A, 32'h8);
        chk("bp_head_word", inst, 32'hE3A0_0001);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, '0);

        // Fill the buffer, then drop reset between edges.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("async_rst");
        sb.delete(); m_fpc = RPC1; m_cnt = 0;
        fetch_en = 1'b0; inst_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stream from reset at full rate.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, '0);

        // Redirect during streaming.
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        chk("br_imem_A", imem_A, 32'h100);
        chk("br_bubble", {31'd0, inst_valid}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, '0);
        chk("br_inst_pc", inst_pc, 32'h100);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, '0);

        // Redirect with a full buffer while the head is popped.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk("brfull_flushed", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, '0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 11) == 0, $urandom);
        end

        // Idle the first instance; run the wrap-around instance.
        fetch_en = 1'b0; inst_ready = 1'b0; br_valid = 1'b0;
        rst2_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("wrap_empty", {31'd0, inst_valid2}, 32'd0);
                chk("wrap_imem_A", imem_A2, RPC2);
            end else begin
                chk("wrap_valid", {31'd0, inst_valid2}, 32'd1);
                chk("wrap_inst_pc", inst_pc2, RPC2 + 32'(4 * (i - 1)));
                chk("wrap_inst", inst2, memword(RPC2 + 32'(4 * (i - 1))));
                chk("wrap_inst_pc8", inst_pc8_2, RPC2 + 32'(4 * (i - 1)) + 32'd8);
            end
        end
        chk("wrap_last_pc8", inst_pc8_2, 32'h8);
        chk("wrap_fetch_cnt", fetch_cnt2, 32'd2);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
